// File: rtl/axis_load_sequencer.sv
// Walks a latched channel mask lowest-first, steering the PS stream to one DAC channel at a time.
// The stream gate opens only after the registered one-hot select has settled.
module axis_load_sequencer #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NUM_CH-1:0] channel_mask_i,
  input  logic [CNT_W-1:0]  beats_i,
  input  logic [DATA_W-1:0] s_axis_tdata_i,
  input  logic              s_axis_tvalid_i,
  output logic              s_axis_tready_o,
  output logic [DATA_W-1:0] m_axis_tdata_o,
  output logic              m_axis_tvalid_o,
  input  logic              m_axis_tready_i,
  output logic [NUM_CH-1:0] channel_select_o,
  output logic [3:0]        cur_channel_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o
);

  typedef enum logic [1:0] {StIdle, StSelect, StStream, StNext} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          settle_q, settle_d;
  logic [NUM_CH-1:0]   sel_q, sel_d;
  logic [3:0]          cur_q, cur_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic [3:0]          low_idx;
  logic                gate;
  logic                hs;

  always_comb begin
    low_idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = 4'(i);
    end
  end

  assign gate = (state_q == StStream);
  assign hs   = gate & s_axis_tvalid_i & m_axis_tready_i;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    beats_d   = beats_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    sel_d     = sel_q;
    cur_d     = cur_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pending_d = channel_mask_i;
          beats_d   = beats_i;
          if ((|channel_mask_i) && (|beats_i)) state_d = StSelect;
          else                                 done_d  = 1'b1;
        end
      end
      StSelect: begin
        // Select is reloaded every cycle here; the gate waits SETTLE cycles after it lands.
        sel_d          = '0;
        sel_d[low_idx] = 1'b1;
        cur_d          = low_idx;
        settle_d       = settle_q + 4'd1;
        if (settle_q == 4'(SETTLE)) begin
          settle_d = '0;
          state_d  = StStream;
        end
      end
      StStream: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == beats_q) state_d = StNext;
        end
      end
      StNext: begin
        sel_d     = '0;
        pending_d = pending_q & ~sel_q;
        cnt_d     = '0;
        if (|pending_d) begin
          state_d = StSelect;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      sel_d     = '0;
      pending_d = '0;
      cnt_d     = '0;
      settle_d  = '0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pending_q <= '0;
      beats_q   <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
      sel_q     <= '0;
      cur_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      beats_q   <= beats_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      sel_q     <= sel_d;
      cur_q     <= cur_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign m_axis_tdata_o   = s_axis_tdata_i;
  assign m_axis_tvalid_o  = gate & s_axis_tvalid_i;
  assign s_axis_tready_o  = gate & m_axis_tready_i;
  assign channel_select_o = sel_q;
  assign cur_channel_o    = cur_q;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done_q;
  assign aborted_o        = aborted_q;

endmodule

// File: doc/axis_load_sequencer.md
# axis_load_sequencer

Sequences PS-to-PL waveform loading across the 16 DAC channels. Sits between the PS stream and the one-hot AXI-Stream channel selector. It drives the selector's `channel_select` port and gates the stream. For each channel in a latched mask, it selects the channel, waits for the selector's select register to settle, and passes exactly `beats` handshakes. It then deselects and moves on to the next channel.

## Interface
- `DATA_W`, 256: stream data width.
- `NUM_CH`, 16: channel count (width of `channel_mask` and `channel_select`).
- `CNT_W`, 16: width of the beat count.
- `SETTLE`, 2: cycles the gate stays closed after a new select (legal 1..15).

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle load request.
- `abort` in 1: one-cycle cancel.
- `channel_mask` in NUM_CH: channels to load; sampled on an accepted start.
- `beats` in CNT_W: beats per channel; sampled on an accepted start.
- `s_axis_tdata` in DATA_W, `s_axis_tvalid` in 1, `s_axis_tready` out 1: from the PS.
- `m_axis_tdata` out DATA_W, `m_axis_tvalid` out 1, `m_axis_tready` in 1: to the selector.
- `channel_select` out NUM_CH: registered one-hot, or zero.
- `cur_channel` out 4: index of the channel being loaded.
- `busy` out 1, `done` out 1, `aborted` out 1: status (`done` and `aborted` are pulses).

## Operation
- **States:** IDLE, SELECT, STREAM, NEXT.
- **IDLE:**
  - A `start` latches `channel_mask` into `pending` and `beats` into `beats_q`.
  - If the mask is nonzero and `beats` is nonzero, go to SELECT.
  - Otherwise pulse `done` next cycle and stay in IDLE.
- **SELECT:**
  - `channel_select` = one-hot of the lowest set bit of `pending`; `cur_channel` = its index.
  - The settle counter runs SETTLE cycles, then the block moves to STREAM.
- **STREAM:**
  - The gate is open: `m_axis_tvalid = s_axis_tvalid`, `s_axis_tready = m_axis_tready`, and `m_axis_tdata = s_axis_tdata` always.
  - The beat counter increments on each `m_axis_tvalid && m_axis_tready`.
  - The handshake that makes the count equal `beats_q` moves the block to NEXT.
- **NEXT (1 cycle):**
  - `channel_select` = 0, the current bit of `pending` is cleared, and the beat counter is cleared.
  - If any `pending` bits remain, go to SELECT. Otherwise go to IDLE and pulse `done`.
- **Gate:** outside STREAM, `m_axis_tvalid` = 0 and `s_axis_tready` = 0. No beat can ever reach a stale or zero select.
- **Busy:** `busy` = 1 in every state except IDLE.
- **Start handling:** `start` while busy is ignored. `channel_mask` and `beats` changes after acceptance have no effect.
- **Abort:**
  - `abort` in any non-IDLE state goes to IDLE next cycle.
  - That cycle: `channel_select` = 0, gate closed, `pending` cleared, one-cycle `aborted` pulse, no `done`.
  - A handshake in the abort cycle still counts as transferred, but it is not reported.
  - `abort` in IDLE is ignored.
  - Simultaneous `start` and `abort` in IDLE: `start` wins.
- **Counter:** compared at CNT_W bits; `beats` = 65535 is legal. The counter never wraps because it clears in NEXT.

## Timing
- **Reset values:**
  - State IDLE, `channel_select` = 0, `cur_channel` = 0.
  - `busy`, `done`, `aborted` all 0; the beat and settle counters 0.
  - `s_axis_tready` = 0 and `m_axis_tvalid` = 0.
- **Mid-operation reset:** the block returns to the reset values immediately (asynchronously). A partial load is abandoned.
- **Start to first beat:**
  - `start` is sampled at edge 0.
  - `channel_select` is valid after edge 1.
  - The gate opens after edge 1+SETTLE, so the first handshake is possible in cycle 1+SETTLE.
- **Last beat to next beat:** the last handshake is at edge k. Edge k+1 gives NEXT (select 0). Edge k+2 gives SELECT (new one-hot). The gate reopens at edge k+2+SETTLE.
- **Done timing:** `done` is high for the cycle after NEXT, for exactly 1 cycle. `busy` falls on the same edge.
- **Output timing:** all status outputs and `channel_select` are registered. The gate and tdata paths are combinational from state and stream inputs.

## Test plan
- **Single channel:** mask 0x0004, beats 3, tvalid/tready held 1 → `channel_select` = 0x0004 for 1+SETTLE+3 cycles. Exactly 3 beats pass with `cur_channel` = 2, then `done` pulses once.
- **Three channels with backpressure:** mask 0x8101, beats 2, random tready → 2 beats each to channels 0, 8, 15 in order. `channel_select` = 0 for one cycle between channels. Zero beats pass outside STREAM.
- **Degenerate starts:** mask 0 or beats 0 → `done` the cycle after `start`. `busy` and `channel_select` stay 0.
- **Abort:** abort at beat 1 of 4 on mask 0x0003 → `aborted` pulse, select 0 next cycle, no `done`, channel 1 never selected.
- **Ignored inputs:** `start` while busy, with a different mask → ignored, and the original sequence completes unchanged.
- **Reset mid-stream:** assert `resetn` low during STREAM → all outputs reach their reset values without waiting for a clock edge. A following start runs a clean sequence.
